// File: rtl/ct_spsram_1024x64_arb.sv
// ct_spsram_1024x64_arb
// Two-port round-robin arbiter in front of a single-port SRAM macro
// (active-low CEN/GWEN/WEN, one-cycle read latency).
// Optional zero-fill sweep after reset: define SPSRAM_ARB_INIT_EN to enable it.
// Without the macro the block is ready the first cycle after reset.
module ct_spsram_1024x64_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    output logic                  req0_rdy,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  req1_rdy,
    output logic                  rsp0_vld,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  init_done
);

    localparam int NPORT = 2;

    // Per-port request fields gathered into vectors so the datapath can index by grant.
    logic [NPORT-1:0]                 req_vld;
    logic [NPORT-1:0]                 req_wr;
    logic [NPORT-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NPORT-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NPORT-1:0][DATA_WIDTH-1:0] req_wmask;

    assign req_vld   = {req1_vld, req0_vld};
    assign req_wr    = {req1_wr, req0_wr};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};
    assign req_wmask = {req1_wmask, req0_wmask};

    logic                  run;         // controller is serving requests
    logic                  sweep;       // zero-fill write this cycle
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef SPSRAM_ARB_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;

    // State and sweep-counter registers; reset restarts the sweep at address 0.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: walk every address once, then hand over to RUN after the last one.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_INIT) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == '1) begin
                state_next = ST_RUN;
            end
        end
    end

    assign run        = (state_reg == ST_RUN);
    assign sweep      = (state_reg == ST_INIT) && cpurst_b;
    assign sweep_addr = cnt_reg;
`else
    logic run_reg;

    // Ready flag: low while reset is applied, high from the first edge after release.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    assign run        = run_reg;
    assign sweep      = 1'b0;
    assign sweep_addr = '0;
`endif

    // Outputs are also qualified by the reset input so nothing is granted or
    // reported during the cycle in which reset is being sampled.
    logic active;
    assign active    = run && cpurst_b;
    assign init_done = active;

    logic [NPORT-1:0] gnt;
    logic             sel;       // index of the granted port
    logic             access;    // any port granted this cycle
    logic             prio_reg;  // 0: port 0 wins a tie, 1: port 1 wins a tie

    // Combinational grant: a lone requester wins, a tie goes to the port favoured by prio_reg.
    always_comb begin
        gnt = '0;
        if (active) begin
            if (&req_vld) begin
                gnt = prio_reg ? 2'b10 : 2'b01;
            end else begin
                gnt = req_vld;
            end
        end
    end

    assign sel    = gnt[1];
    assign access = |gnt;

    // Round-robin pointer: after a grant, favour the other port; idle cycles leave it alone.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            prio_reg <= 1'b0;
        end else if (access) begin
            prio_reg <= ~sel;
        end
    end

    logic [ADDR_WIDTH-1:0] a_hold_reg;
    logic [DATA_WIDTH-1:0] d_hold_reg;

    // Remember the last driven address/data so idle cycles keep the SRAM pins quiet.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            a_hold_reg <= '0;
            d_hold_reg <= '0;
        end else begin
            a_hold_reg <= sram_a;
            d_hold_reg <= sram_d;
        end
    end

    // SRAM pin drive: sweep write, granted access, or idle with held address/data.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_hold_reg;
        sram_d    = d_hold_reg;
        if (sweep) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = '0;
            sram_a    = sweep_addr;
        end else if (access) begin
            sram_cen = 1'b0;
            sram_a   = req_addr[sel];
            if (req_wr[sel]) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask[sel];
                sram_d    = req_wdata[sel];
            end
        end
    end

    logic [NPORT-1:0] rd_pend_reg;

    // Read-pending flags: one-hot on the port whose read was issued last cycle.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            rd_pend_reg <= '0;
        end else begin
            rd_pend_reg <= gnt & ~req_wr;
        end
    end

    logic [NPORT-1:0] rdy_vec;
    logic [NPORT-1:0] rsp_vec;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign rdy_vec[gi] = gnt[gi];
            assign rsp_vec[gi] = rd_pend_reg[gi] && cpurst_b;
        end
    endgenerate

    assign req0_rdy   = rdy_vec[0];
    assign req1_rdy   = rdy_vec[1];
    assign rsp0_vld   = rsp_vec[0];
    assign rsp1_vld   = rsp_vec[1];
    assign rsp0_rdata = sram_q;
    assign rsp1_rdata = sram_q;

endmodule

// File: tb/tb_ct_spsram_1024x64_arb.sv
// Testbench for ct_spsram_1024x64_arb: behavioural SRAM model, a table of
// per-cycle vectors for the arbitration/datapath, and hand-written sequences
// for reset, sweep (when SPSRAM_ARB_INIT_EN is defined) and reset mid-read.
module tb_ct_spsram_1024x64_arb;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam logic [63:0] ONES = '1;
    localparam logic [63:0] SEED = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] DB   = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D1   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D2   = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DA   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] M16  = 64'h0000_0000_FFFF_0000;
    localparam logic [63:0] MRES = 64'hFFFF_FFFF_0000_FFFF;

    logic forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    logic          cpurst_b;
    logic          req0_vld, req0_wr, req1_vld, req1_wr;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
    logic          req0_rdy, req1_rdy, rsp0_vld, rsp1_vld;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [DW-1:0] sram_q;
    logic          init_done;

    ct_spsram_1024x64_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
        .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_rdy(req1_rdy),
        .rsp0_vld(rsp0_vld), .rsp0_rdata(rsp0_rdata),
        .rsp1_vld(rsp1_vld), .rsp1_rdata(rsp1_rdata),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q),
        .init_done(init_done)
    );

    // Behavioural single-port SRAM: bit-masked write, registered read.
    logic [DW-1:0] mem [1024];
    logic          seeded = 1'b0;
    always @(posedge forever_cpuclk) begin
        if (!seeded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= SEED;
            seeded <= 1'b1;
        end else if (sram_cen == 1'b0) begin
            if (sram_gwen == 1'b0) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else                   sram_q <= mem[sram_a];
        end
    end

    typedef struct packed {
        logic          vld;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
    } req_t;

    typedef struct {
        req_t          r0;
        req_t          r1;
        logic [1:0]    e_rdy;   // {rdy1, rdy0}
        logic          e_cen;
        logic          e_gwen;
        logic [DW-1:0] e_wen;
        logic [AW-1:0] e_a;
        logic [1:0]    e_rsp;   // {rsp1, rsp0}
        logic [DW-1:0] e_rdata;
    } vec_t;

    localparam req_t NO = '0;

    function automatic req_t RD(input logic [AW-1:0] a);
        req_t r;
        r = '0; r.vld = 1'b1; r.wr = 1'b0; r.addr = a;
        return r;
    endfunction

    function automatic req_t WR(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_t r;
        r.vld = 1'b1; r.wr = 1'b1; r.addr = a; r.wdata = d; r.wmask = m;
        return r;
    endfunction

    function automatic vec_t V(input req_t r0, input req_t r1, input logic [1:0] rdy,
                               input logic cen, input logic gwen, input logic [DW-1:0] wen,
                               input logic [AW-1:0] a, input logic [1:0] rsp, input logic [DW-1:0] rdata);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.e_rdy = rdy; v.e_cen = cen; v.e_gwen = gwen;
        v.e_wen = wen; v.e_a = a; v.e_rsp = rsp; v.e_rdata = rdata;
        return v;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic drive(input req_t r0, input req_t r1);
        req0_vld = r0.vld; req0_wr = r0.wr; req0_addr = r0.addr; req0_wdata = r0.wdata; req0_wmask = r0.wmask;
        req1_vld = r1.vld; req1_wr = r1.wr; req1_addr = r1.addr; req1_wdata = r1.wdata; req1_wmask = r1.wmask;
    endtask

    task automatic step();
        @(negedge forever_cpuclk);
    endtask

`ifdef SPSRAM_ARB_INIT_EN
    task automatic count_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 3000) begin
            n++;
            step(); #1;
        end
    endtask
`endif

    vec_t vecs [21];

    initial begin
        int n;
        int k;
        vecs[0]  = V(WR(10'h155, DB, ONES), NO,   2'b01, 1'b0, 1'b0, 64'h0, 10'h155, 2'b00, 64'h0);
        vecs[1]  = V(RD(10'h155), NO,             2'b01, 1'b0, 1'b1, ONES,  10'h155, 2'b00, 64'h0);
        vecs[2]  = V(NO, NO,                      2'b00, 1'b1, 1'b1, ONES,  10'h155, 2'b01, DB);
        vecs[3]  = V(WR(10'h002, D2, ONES), NO,   2'b01, 1'b0, 1'b0, 64'h0, 10'h002, 2'b00, 64'h0);
        vecs[4]  = V(NO, WR(10'h001, D1, ONES),   2'b10, 1'b0, 1'b0, 64'h0, 10'h001, 2'b00, 64'h0);
        vecs[5]  = V(RD(10'h001), RD(10'h002),    2'b01, 1'b0, 1'b1, ONES,  10'h001, 2'b00, 64'h0);
        vecs[6]  = V(RD(10'h001), RD(10'h002),    2'b10, 1'b0, 1'b1, ONES,  10'h002, 2'b01, D1);
        vecs[7]  = V(RD(10'h001), RD(10'h002),    2'b01, 1'b0, 1'b1, ONES,  10'h001, 2'b10, D2);
        vecs[8]  = V(RD(10'h001), RD(10'h002),    2'b10, 1'b0, 1'b1, ONES,  10'h002, 2'b01, D1);
        vecs[9]  = V(NO, NO,                      2'b00, 1'b1, 1'b1, ONES,  10'h002, 2'b10, D2);
        vecs[10] = V(WR(10'h010, ONES, ONES), NO, 2'b01, 1'b0, 1'b0, 64'h0, 10'h010, 2'b00, 64'h0);
        vecs[11] = V(NO, WR(10'h010, 64'h0, M16), 2'b10, 1'b0, 1'b0, MRES,  10'h010, 2'b00, 64'h0);
        vecs[12] = V(RD(10'h010), NO,             2'b01, 1'b0, 1'b1, ONES,  10'h010, 2'b00, 64'h0);
        vecs[13] = V(NO, NO,                      2'b00, 1'b1, 1'b1, ONES,  10'h010, 2'b01, MRES);
        vecs[14] = V(NO, WR(10'h155, 64'h0, 64'h0), 2'b10, 1'b0, 1'b0, ONES, 10'h155, 2'b00, 64'h0);
        vecs[15] = V(NO, RD(10'h155),             2'b10, 1'b0, 1'b1, ONES,  10'h155, 2'b00, 64'h0);
        vecs[16] = V(NO, NO,                      2'b00, 1'b1, 1'b1, ONES,  10'h155, 2'b10, DB);
        vecs[17] = V(WR(10'h200, DA, ONES), RD(10'h155), 2'b01, 1'b0, 1'b0, 64'h0, 10'h200, 2'b00, 64'h0);
        vecs[18] = V(RD(10'h200), RD(10'h155),    2'b10, 1'b0, 1'b1, ONES,  10'h155, 2'b00, 64'h0);
        vecs[19] = V(RD(10'h200), RD(10'h155),    2'b01, 1'b0, 1'b1, ONES,  10'h200, 2'b10, DB);
        vecs[20] = V(NO, NO,                      2'b00, 1'b1, 1'b1, ONES,  10'h200, 2'b01, DA);

        // Reset with a pending port-0 request: nothing may be granted.
        cpurst_b = 1'b0;
        drive(RD(10'h000), NO);
        repeat (3) step();
        #1;
        $display("reset: init_done=%b rdy=%b%b cen=%b gwen=%b rsp=%b%b", init_done, req1_rdy, req0_rdy, sram_cen, sram_gwen, rsp1_vld, rsp0_vld);
        chk("rst.init_done", 64'(init_done), 64'(1'b0));
        chk("rst.rdy0", 64'(req0_rdy), 64'(1'b0));
        chk("rst.rdy1", 64'(req1_rdy), 64'(1'b0));
        chk("rst.cen", 64'(sram_cen), 64'(1'b1));
        chk("rst.gwen", 64'(sram_gwen), 64'(1'b1));
        chk("rst.wen", sram_wen, ONES);
        chk("rst.rsp0", 64'(rsp0_vld), 64'(1'b0));
        chk("rst.rsp1", 64'(rsp1_vld), 64'(1'b0));

        // Release reset with a mask-0 write probe on port 0.
        step();
        cpurst_b = 1'b1;
        drive(WR(10'h000, 64'h0, 64'h0), NO);
        #1;
`ifdef SPSRAM_ARB_INIT_EN
        chk("sweep0.a", 64'(sram_a), 64'(10'h000));
        chk("sweep0.cen", 64'(sram_cen), 64'(1'b0));
        chk("sweep0.gwen", 64'(sram_gwen), 64'(1'b0));
        chk("sweep0.wen", sram_wen, 64'h0);
        chk("sweep0.d", sram_d, 64'h0);
        chk("sweep0.rdy0", 64'(req0_rdy), 64'(1'b0));
        count_init(n);
        $display("sweep: init_done low for %0d cycles", n);
        chk("init_cycles", 64'(n), 64'(1024));
`else
        step(); #1;
`endif
        $display("release: init_done=%b rdy0=%b cen=%b", init_done, req0_rdy, sram_cen);
        chk("rel.init_done", 64'(init_done), 64'(1'b1));
        chk("rel.rdy0", 64'(req0_rdy), 64'(1'b1));
        chk("rel.cen_mask0", 64'(sram_cen), 64'(1'b0));
        chk("rel.wen_mask0", sram_wen, ONES);
`ifdef SPSRAM_ARB_INIT_EN
        step(); drive(RD(10'h3FF), NO); #1;
        chk("rd3ff.rdy0", 64'(req0_rdy), 64'(1'b1));
        step(); drive(NO, NO); #1;
        $display("read 0x3ff: rsp0=%b rdata=%h", rsp0_vld, rsp0_rdata);
        chk("rd3ff.rsp0", 64'(rsp0_vld), 64'(1'b1));
        chk("rd3ff.rdata", rsp0_rdata, 64'h0);
`else
        step(); drive(NO, NO); #1;
`endif

        // Per-cycle vector table.
        for (int i = 0; i < 21; i++) begin
            step();
            drive(vecs[i].r0, vecs[i].r1);
            #1;
            $display("vec %0d: rdy=%b%b cen=%b gwen=%b a=%h wen=%h rsp=%b%b rdata=%h",
                     i, req1_rdy, req0_rdy, sram_cen, sram_gwen, sram_a, sram_wen, rsp1_vld, rsp0_vld, rsp0_rdata);
            chk($sformatf("v%0d.rdy0", i), 64'(req0_rdy), 64'(vecs[i].e_rdy[0]));
            chk($sformatf("v%0d.rdy1", i), 64'(req1_rdy), 64'(vecs[i].e_rdy[1]));
            chk($sformatf("v%0d.cen", i), 64'(sram_cen), 64'(vecs[i].e_cen));
            chk($sformatf("v%0d.gwen", i), 64'(sram_gwen), 64'(vecs[i].e_gwen));
            chk($sformatf("v%0d.wen", i), sram_wen, vecs[i].e_wen);
            chk($sformatf("v%0d.a", i), 64'(sram_a), 64'(vecs[i].e_a));
            chk($sformatf("v%0d.rsp0", i), 64'(rsp0_vld), 64'(vecs[i].e_rsp[0]));
            chk($sformatf("v%0d.rsp1", i), 64'(rsp1_vld), 64'(vecs[i].e_rsp[1]));
            if (vecs[i].e_rsp[0]) chk($sformatf("v%0d.rdata0", i), rsp0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rsp[1]) chk($sformatf("v%0d.rdata1", i), rsp1_rdata, vecs[i].e_rdata);
            if (!vecs[i].e_gwen)
                chk($sformatf("v%0d.d", i), sram_d, vecs[i].e_rdy[0] ? vecs[i].r0.wdata : vecs[i].r1.wdata);
        end

        // Reset while a read response is pending: the response must be dropped.
        step(); drive(RD(10'h200), NO); #1;
        chk("midrd.rdy0", 64'(req0_rdy), 64'(1'b1));
        step(); cpurst_b = 1'b0; drive(NO, NO); #1;
        $display("mid-read reset: rsp0=%b cen=%b init_done=%b", rsp0_vld, sram_cen, init_done);
        chk("midrd.rsp0", 64'(rsp0_vld), 64'(1'b0));
        chk("midrd.cen", 64'(sram_cen), 64'(1'b1));
        chk("midrd.init_done", 64'(init_done), 64'(1'b0));
        step(); cpurst_b = 1'b1; drive(RD(10'h155), RD(10'h001)); #1;
        chk("midrd.rel_rsp0", 64'(rsp0_vld), 64'(1'b0));
`ifdef SPSRAM_ARB_INIT_EN
        chk("midrd.rel_a", 64'(sram_a), 64'(10'h000));
        chk("midrd.rel_rdy0", 64'(req0_rdy), 64'(1'b0));
        // Walk the sweep to address 500, pulse reset for one cycle, expect a full restart.
        k = 0;
        while (sram_a !== 10'd500 && k < 2000) begin
            k++;
            step(); #1;
        end
        chk("sweep.reach500", 64'(sram_a), 64'(10'd500));
        step(); cpurst_b = 1'b0; #1;
        step(); cpurst_b = 1'b1; #1;
        chk("restart.a", 64'(sram_a), 64'(10'h000));
        count_init(n);
        $display("restart sweep: init_done low for %0d cycles", n);
        chk("restart.init_cycles", 64'(n), 64'(1024));
`else
        step(); #1;
`endif
        // Pointer favours port 0 after reset; then the other port on the next tie.
        $display("post-reset tie: init_done=%b rdy=%b%b", init_done, req1_rdy, req0_rdy);
        chk("tie.init_done", 64'(init_done), 64'(1'b1));
        chk("tie.rdy0", 64'(req0_rdy), 64'(1'b1));
        chk("tie.rdy1", 64'(req1_rdy), 64'(1'b0));
        step(); #1;
        $display("post-reset tie+1: rdy=%b%b rsp=%b%b", req1_rdy, req0_rdy, rsp1_vld, rsp0_vld);
        chk("tie2.rdy0", 64'(req0_rdy), 64'(1'b0));
        chk("tie2.rdy1", 64'(req1_rdy), 64'(1'b1));
        chk("tie2.rsp0", 64'(rsp0_vld), 64'(1'b1));
        chk("tie2.rsp1", 64'(rsp1_vld), 64'(1'b0));
        step(); drive(NO, NO); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
